// File: rtl/dcache_refill_ctrl_if.sv
// ----------------------------------------------------------------------------
// dcache_refill_ctrl_if
// Burst bus between the data-cache refill controller and the memory side.
//   req_*   : one request per burst (write=1 writeback, write=0 refill),
//             line-aligned address, valid/ready handshake
//   r*      : refill read beats from memory (rvalid/rdata/rlast)
//   w*      : writeback beats to memory (wvalid/wready/wdata/wlast)
//   bvalid  : writeback burst completion response
// The master modport is the cache controller; the slave modport is memory.
// ----------------------------------------------------------------------------
interface dcache_refill_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              rlast;
  logic              wvalid;
  logic              wready;
  logic [31:0]       wdata;
  logic              wlast;
  logic              bvalid;

  modport master (
    output req_valid, req_write, req_addr, wvalid, wdata, wlast,
    input  req_ready, rvalid, rdata, rlast, wready, bvalid
  );

  modport slave (
    input  req_valid, req_write, req_addr, wvalid, wdata, wlast,
    output req_ready, rvalid, rdata, rlast, wready, bvalid
  );
endinterface

// File: rtl/dcache_refill_ctrl.sv
// ----------------------------------------------------------------------------
// dcache_refill_ctrl
// Miss handler for one data-cache way. On an accepted miss it optionally
// writes back the dirty victim line (read from the data RAM, buffered, then
// burst out), invalidates the tag, refills the 4-word line from the bus into
// the data RAM and finally writes the new valid/clean tag.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   miss_valid_i/ready_o miss request handshake (ready only when idle)
//   miss_paddr_i        missing physical address (line index [11:4])
//   victim_tag_i        {valid, dirty, paddr[31:12]} of the line in the set
//   done_o              one-cycle pulse when the new tag is written
//   dp_r_addr_o/data_i  data RAM read port (1-cycle read latency)
//   dp_w_addr_o, dp_data_we_o, dp_data_o   data RAM write port
//   dp_tag_we_o, dp_tag_o                  tag RAM write port
//   bus                 burst bus, master side
// ----------------------------------------------------------------------------
module dcache_refill_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int BUS_ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  miss_valid_i,
  output logic                  miss_ready_o,
  input  logic [BUS_ADDR_W-1:0] miss_paddr_i,
  input  logic [21:0]           victim_tag_i,
  output logic                  done_o,
  output logic [9:0]            dp_r_addr_o,
  input  logic [31:0]           dp_data_i,
  output logic [9:0]            dp_w_addr_o,
  output logic [3:0]            dp_data_we_o,
  output logic [31:0]           dp_data_o,
  output logic                  dp_tag_we_o,
  output logic [21:0]           dp_tag_o,
  dcache_refill_ctrl_if.master  bus
);

  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
  // The read phase needs one extra cycle to catch the last RAM word.
  localparam logic [BEAT_W:0] RD_DONE = (BEAT_W + 1)'(LINE_WORDS);

  typedef enum logic [3:0] {
    IDLE,
    WB_READ,
    WB_REQ,
    WB_DATA,
    WB_RESP,
    INV,
    RF_REQ,
    RF_DATA,
    TAG_WR
  } state_e;

  state_e                  state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [BEAT_W:0]         rd_step_q, rd_step_d;
  logic [BUS_ADDR_W-1:4]   paddr_q, paddr_d;
  logic [19:0]             victim_q, victim_d;
  logic [31:0]             wb_buf_q [LINE_WORDS];
  logic [31:0]             wb_buf_d [LINE_WORDS];
  logic [BEAT_W-1:0]       cap_idx;
  logic                    rf_beat;

  // The byte offset of the miss address never matters: refills are whole lines.
  logic unused_paddr_lo;
  assign unused_paddr_lo = ^miss_paddr_i[3:0];

  // Next-state logic. Request inputs are only looked at in IDLE, and each
  // bus input only in the state that owns it, so stray beats are harmless.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    rd_step_d = rd_step_q;
    paddr_d   = paddr_q;
    victim_d  = victim_q;
    wb_buf_d  = wb_buf_q;
    cap_idx   = rd_step_q[BEAT_W-1:0] - BEAT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (miss_valid_i) begin
          paddr_d  = miss_paddr_i[BUS_ADDR_W-1:4];
          victim_d = victim_tag_i[19:0];
          state_d  = (victim_tag_i[21] && victim_tag_i[20]) ? WB_READ : INV;
        end
      end
      WB_READ: begin
        // Step k issues read k; the data for read k-1 arrives on step k.
        if (rd_step_q != '0) begin
          wb_buf_d[cap_idx] = dp_data_i;
        end
        if (rd_step_q == RD_DONE) begin
          state_d = WB_REQ;
        end else begin
          rd_step_d = rd_step_q + 1'b1;
        end
      end
      WB_REQ: begin
        if (bus.req_ready) state_d = WB_DATA;
      end
      WB_DATA: begin
        if (bus.wready) begin
          if (beat_q == LAST_BEAT) state_d = WB_RESP;
          else                     beat_d  = beat_q + 1'b1;
        end
      end
      WB_RESP: begin
        if (bus.bvalid) state_d = INV;
      end
      INV: begin
        state_d = RF_REQ;
      end
      RF_REQ: begin
        if (bus.req_ready) state_d = RF_DATA;
      end
      RF_DATA: begin
        // The beat counter is authoritative; rlast only ends the burst on
        // the beat the counter expects to be last.
        if (bus.rvalid) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT && bus.rlast) state_d = TAG_WR;
        end
      end
      TAG_WR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Every state starts counting from zero.
    if (state_d != state_q) begin
      beat_d    = '0;
      rd_step_d = '0;
    end
  end

  // All controller state, asynchronously cleared so reset aborts at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      rd_step_q <= '0;
      paddr_q   <= '0;
      victim_q  <= '0;
      for (int i = 0; i < LINE_WORDS; i++) wb_buf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      rd_step_q <= rd_step_d;
      paddr_q   <= paddr_d;
      victim_q  <= victim_d;
      wb_buf_q  <= wb_buf_d;
    end
  end

  // Outputs decode the registered state only, except the refill write port
  // which forwards each bus beat into the RAM in the cycle it arrives.
  // Every field is forced to zero when not in use.
  always_comb begin
    rf_beat        = (state_q == RF_DATA) && bus.rvalid;

    miss_ready_o   = (state_q == IDLE);
    done_o         = (state_q == TAG_WR);

    dp_r_addr_o    = '0;
    if (state_q == WB_READ && rd_step_q < RD_DONE) begin
      dp_r_addr_o  = {paddr_q[11:4], rd_step_q[BEAT_W-1:0]};
    end

    dp_data_we_o   = rf_beat ? 4'hf : 4'h0;
    dp_w_addr_o    = rf_beat ? {paddr_q[11:4], beat_q} : 10'h0;
    dp_data_o      = rf_beat ? bus.rdata : 32'h0;

    // INV clears the tag first so a half-refilled line is never a hit.
    dp_tag_we_o    = (state_q == INV) || (state_q == TAG_WR);
    dp_tag_o       = (state_q == TAG_WR) ? {1'b1, 1'b0, paddr_q[31:12]} : 22'h0;

    bus.req_valid  = (state_q == WB_REQ) || (state_q == RF_REQ);
    bus.req_write  = (state_q == WB_REQ);
    bus.req_addr   = '0;
    if (state_q == WB_REQ) bus.req_addr = {victim_q, paddr_q[11:4], 4'h0};
    if (state_q == RF_REQ) bus.req_addr = {paddr_q, 4'h0};

    bus.wvalid     = (state_q == WB_DATA);
    bus.wdata      = (state_q == WB_DATA) ? wb_buf_q[beat_q] : 32'h0;
    bus.wlast      = (state_q == WB_DATA) && (beat_q == LAST_BEAT);
  end

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dcache_refill_ctrl
// Directed bench for the refill controller. A passive monitor logs every RAM
// write, bus request, writeback beat and done pulse; scenario tasks drive the
// miss port and act as the memory/bus, then compare the logs with expected
// values worked out by hand from the addresses used.
// ----------------------------------------------------------------------------
module tb_dcache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        miss_valid_i;
  logic        miss_ready_o;
  logic [31:0] miss_paddr_i;
  logic [21:0] victim_tag_i;
  logic        done_o;
  logic [9:0]  dp_r_addr_o;
  logic [31:0] dp_data_i;
  logic [9:0]  dp_w_addr_o;
  logic [3:0]  dp_data_we_o;
  logic [31:0] dp_data_o;
  logic        dp_tag_we_o;
  logic [21:0] dp_tag_o;

  dcache_refill_ctrl_if #(.ADDR_W(32)) bus ();

  dcache_refill_ctrl #(.LINE_WORDS(4), .BUS_ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .miss_valid_i (miss_valid_i),
    .miss_ready_o (miss_ready_o),
    .miss_paddr_i (miss_paddr_i),
    .victim_tag_i (victim_tag_i),
    .done_o       (done_o),
    .dp_r_addr_o  (dp_r_addr_o),
    .dp_data_i    (dp_data_i),
    .dp_w_addr_o  (dp_w_addr_o),
    .dp_data_we_o (dp_data_we_o),
    .dp_data_o    (dp_data_o),
    .dp_tag_we_o  (dp_tag_we_o),
    .dp_tag_o     (dp_tag_o),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [147:0] all_outs;
  assign all_outs = {done_o, dp_r_addr_o, dp_w_addr_o, dp_data_we_o, dp_data_o,
                     dp_tag_we_o, dp_tag_o, bus.req_valid, bus.req_write,
                     bus.req_addr, bus.wvalid, bus.wdata, bus.wlast};

  // Monitor logs
  logic [9:0]  dw_addr [$];
  logic [31:0] dw_data [$];
  logic [21:0] tw_tag [$];
  logic [31:0] wb_data [$];
  logic        wb_last [$];
  logic [31:0] rq_addr [$];
  logic        rq_write [$];
  int          rq_cyc [$];
  int          done_cyc [$];
  int          overlap_cnt = 0;
  int          unstable_cnt = 0;
  int          wlast_hs_cnt = 0;
  int          rf_req_cnt = 0;
  int          bvalid_cyc = 0;
  logic [31:0] rbase;

  bit          req_held = 0;
  logic [31:0] held_addr;
  logic        held_write;
  bit          w_held = 0;
  logic [31:0] held_wdata;
  logic        held_wlast;

  // Passive monitor: samples mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      req_held = 0;
      w_held   = 0;
    end else begin
      if (dp_data_we_o != 4'h0) begin
        dw_addr.push_back(dp_w_addr_o);
        dw_data.push_back(dp_data_o);
      end
      if (dp_tag_we_o) tw_tag.push_back(dp_tag_o);
      if (dp_tag_we_o && dp_data_we_o != 4'h0) overlap_cnt++;
      if (done_o) done_cyc.push_back(cyc);
      if (req_held && (bus.req_valid !== 1'b1 || bus.req_addr !== held_addr ||
                       bus.req_write !== held_write)) unstable_cnt++;
      if (w_held && (bus.wvalid !== 1'b1 || bus.wdata !== held_wdata ||
                     bus.wlast !== held_wlast)) unstable_cnt++;
      req_held   = bus.req_valid && !bus.req_ready;
      held_addr  = bus.req_addr;
      held_write = bus.req_write;
      w_held     = bus.wvalid && !bus.wready;
      held_wdata = bus.wdata;
      held_wlast = bus.wlast;
      if (bus.req_valid && bus.req_ready) begin
        rq_addr.push_back(bus.req_addr);
        rq_write.push_back(bus.req_write);
        rq_cyc.push_back(cyc);
        if (!bus.req_write) rf_req_cnt++;
      end
      if (bus.wvalid && bus.wready) begin
        wb_data.push_back(bus.wdata);
        wb_last.push_back(bus.wlast);
        if (bus.wlast) wlast_hs_cnt++;
      end
    end
  end

  task automatic clear_bus();
    bus.req_ready = 0;
    bus.rvalid    = 0;
    bus.rdata     = 0;
    bus.rlast     = 0;
    bus.wready    = 0;
    bus.bvalid    = 0;
  endtask

  // Acts as data RAM and memory until done_target done pulses have been seen
  // or, if stop_beats>0, that many refill beats have been delivered.
  task automatic serve(input bit stall, input bit hold, input int done_target,
                       input int stop_beats, output bit timed_out);
    int rk = 0;
    bit rf_act = 0;
    bit bpend = 0;
    int seen_rf = rf_req_cnt;
    int seen_wl = wlast_hs_cnt;
    logic [9:0] prev_raddr = dp_r_addr_o;
    timed_out = 1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (!hold) miss_valid_i = 0;
      if (bus.rvalid) rk++;
      if (rf_req_cnt != seen_rf) begin
        seen_rf = rf_req_cnt;
        rf_act  = 1;
        rk      = 0;
      end
      if (rk >= 4) rf_act = 0;
      if (wlast_hs_cnt != seen_wl) begin
        seen_wl = wlast_hs_cnt;
        bpend   = 1;
      end
      if (bus.bvalid) bus.bvalid = 0;
      else if (bpend && (!stall || $urandom_range(0, 2) == 0)) begin
        bus.bvalid = 1;
        bpend      = 0;
        bvalid_cyc = cyc;
      end
      dp_data_i     = 32'hA000_0000 | {22'h0, prev_raddr};
      prev_raddr    = dp_r_addr_o;
      bus.req_ready = bus.req_valid && (!stall || $urandom_range(0, 2) == 0);
      bus.wready    = bus.wvalid && (!stall || $urandom_range(0, 2) == 0);
      if (done_cyc.size() >= done_target || (stop_beats > 0 && rk >= stop_beats)) begin
        timed_out = 0;
        break;
      end
      bus.rvalid = rf_act && (!stall || $urandom_range(0, 2) == 0);
      bus.rdata  = rbase + rk;
      bus.rlast  = (rk == 3);
    end
    clear_bus();
    miss_valid_i = 0;
    checks++;
    if (timed_out) begin
      errors++;
      $display("[TB] FAIL serve_timeout: got no completion within 400 cycles, expected completion");
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (miss_ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b expected 1", miss_ready_o);
    end
    checks++;
    if (all_outs !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outs: got %h expected 0", all_outs);
    end
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (miss_ready_o !== 1'b1 || all_outs !== '0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: got ready=%b outs=%h expected ready=1 outs=0",
               miss_ready_o, all_outs);
    end
  endtask

  task automatic test_clean_miss();
    int nd = dw_addr.size();
    int nt = tw_tag.size();
    int nr = rq_addr.size();
    int nw = wb_data.size();
    int ndn = done_cyc.size();
    int acc;
    bit to;
    rbase = 32'hD000_0000;
    @(posedge clk); #1;
    miss_valid_i = 1; miss_paddr_i = 32'h1234_5670; victim_tag_i = 22'h0;
    acc = cyc;
    serve(0, 0, ndn + 1, 0, to);
    checks++;
    if (done_cyc[ndn] - acc !== 7) begin
      errors++;
      $display("[TB] FAIL clean_latency: got %0d expected 7", done_cyc[ndn] - acc);
    end
    checks++;
    if (dw_addr.size() - nd !== 4) begin
      errors++;
      $display("[TB] FAIL clean_nwrites: got %0d expected 4", dw_addr.size() - nd);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dw_addr[nd+i] !== 10'h19C + 10'(i) || dw_data[nd+i] !== 32'hD000_0000 + i) begin
        errors++;
        $display("[TB] FAIL clean_beat%0d: got addr=%h data=%h expected addr=%h data=%h",
                 i, dw_addr[nd+i], dw_data[nd+i], 10'h19C + 10'(i), 32'hD000_0000 + i);
      end
    end
    checks++;
    if (tw_tag.size() - nt !== 2 || tw_tag[nt] !== 22'h0 || tw_tag[nt+1] !== 22'h212345) begin
      errors++;
      $display("[TB] FAIL clean_tags: got n=%0d t0=%h t1=%h expected n=2 t0=0 t1=212345",
               tw_tag.size() - nt, tw_tag[nt], tw_tag[nt+1]);
    end
    checks++;
    if (rq_addr.size() - nr !== 1 || rq_write[nr] !== 1'b0 || rq_addr[nr] !== 32'h1234_5670) begin
      errors++;
      $display("[TB] FAIL clean_req: got n=%0d w=%b addr=%h expected n=1 w=0 addr=12345670",
               rq_addr.size() - nr, rq_write[nr], rq_addr[nr]);
    end
    checks++;
    if (wb_data.size() !== nw) begin
      errors++;
      $display("[TB] FAIL clean_no_wb: got %0d beats expected 0", wb_data.size() - nw);
    end
  endtask

  task automatic test_dirty_miss();
    int nd = dw_addr.size();
    int nt = tw_tag.size();
    int nr = rq_addr.size();
    int nw = wb_data.size();
    int ndn = done_cyc.size();
    bit to;
    rbase = 32'hE000_0000;
    @(posedge clk); #1;
    miss_valid_i = 1; miss_paddr_i = 32'h5555_5678; victim_tag_i = 22'h3ABCDE;
    serve(0, 0, ndn + 1, 0, to);
    checks++;
    if (rq_addr.size() - nr !== 2 || rq_write[nr] !== 1'b1 || rq_addr[nr] !== 32'hABCD_E670) begin
      errors++;
      $display("[TB] FAIL dirty_wb_req: got n=%0d w=%b addr=%h expected n=2 w=1 addr=abcde670",
               rq_addr.size() - nr, rq_write[nr], rq_addr[nr]);
    end
    checks++;
    if (rq_write[nr+1] !== 1'b0 || rq_addr[nr+1] !== 32'h5555_5670) begin
      errors++;
      $display("[TB] FAIL dirty_rf_req: got w=%b addr=%h expected w=0 addr=55555670",
               rq_write[nr+1], rq_addr[nr+1]);
    end
    checks++;
    if (wb_data.size() - nw !== 4) begin
      errors++;
      $display("[TB] FAIL dirty_nbeats: got %0d expected 4", wb_data.size() - nw);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wb_data[nw+i] !== 32'hA000_019C + i || wb_last[nw+i] !== (i == 3)) begin
        errors++;
        $display("[TB] FAIL dirty_wbeat%0d: got data=%h last=%b expected data=%h last=%b",
                 i, wb_data[nw+i], wb_last[nw+i], 32'hA000_019C + i, (i == 3));
      end
    end
    checks++;
    if (!(rq_cyc[nr+1] > bvalid_cyc)) begin
      errors++;
      $display("[TB] FAIL dirty_order: got refill req cycle %0d expected after bvalid cycle %0d",
               rq_cyc[nr+1], bvalid_cyc);
    end
    checks++;
    if (dw_addr.size() - nd !== 4 || dw_addr[nd+3] !== 10'h19F || dw_data[nd+3] !== 32'hE000_0003) begin
      errors++;
      $display("[TB] FAIL dirty_refill: got n=%0d a3=%h d3=%h expected n=4 a3=19f d3=e0000003",
               dw_addr.size() - nd, dw_addr[nd+3], dw_data[nd+3]);
    end
    checks++;
    if (tw_tag.size() - nt !== 2 || tw_tag[nt] !== 22'h0 || tw_tag[nt+1] !== 22'h255555) begin
      errors++;
      $display("[TB] FAIL dirty_tags: got n=%0d t0=%h t1=%h expected n=2 t0=0 t1=255555",
               tw_tag.size() - nt, tw_tag[nt], tw_tag[nt+1]);
    end
  endtask

  task automatic test_stalls();
    int nd = dw_addr.size();
    int nt = tw_tag.size();
    int nr = rq_addr.size();
    int nw = wb_data.size();
    int ndn = done_cyc.size();
    int nu = unstable_cnt;
    bit to;
    rbase = 32'h7700_0000;
    @(posedge clk); #1;
    miss_valid_i = 1; miss_paddr_i = 32'hCAFE_B2A4; victim_tag_i = 22'h3F0F0F;
    serve(1, 0, ndn + 1, 0, to);
    checks++;
    if (unstable_cnt !== nu) begin
      errors++;
      $display("[TB] FAIL stall_stable: got %0d unstable cycles expected 0", unstable_cnt - nu);
    end
    checks++;
    if (rq_addr[nr] !== 32'hF0F0_F2A0 || rq_addr[nr+1] !== 32'hCAFE_B2A0) begin
      errors++;
      $display("[TB] FAIL stall_reqs: got %h %h expected f0f0f2a0 cafeb2a0", rq_addr[nr], rq_addr[nr+1]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wb_data[nw+i] !== 32'hA000_00A8 + i || dw_addr[nd+i] !== 10'h0A8 + 10'(i) ||
          dw_data[nd+i] !== 32'h7700_0000 + i) begin
        errors++;
        $display("[TB] FAIL stall_order%0d: got wb=%h addr=%h data=%h expected wb=%h addr=%h data=%h",
                 i, wb_data[nw+i], dw_addr[nd+i], dw_data[nd+i],
                 32'hA000_00A8 + i, 10'h0A8 + 10'(i), 32'h7700_0000 + i);
      end
    end
    checks++;
    if (dw_addr.size() - nd !== 4 || tw_tag.size() - nt !== 2 || tw_tag[nt+1] !== 22'h2CAFEB) begin
      errors++;
      $display("[TB] FAIL stall_counts: got data=%0d tags=%0d tag=%h expected 4 2 2cafeb",
               dw_addr.size() - nd, tw_tag.size() - nt, tw_tag[nt+1]);
    end
  endtask

  task automatic test_reset_mid_refill();
    int nd = dw_addr.size();
    int ndn;
    bit to;
    rbase = 32'h3300_0000;
    @(posedge clk); #1;
    miss_valid_i = 1; miss_paddr_i = 32'h0000_1230; victim_tag_i = 22'h0;
    serve(0, 0, 1000, 2, to);
    bus.rvalid = 1; bus.rdata = 32'h3300_0002; #1;
    checks++;
    if (dp_data_we_o !== 4'hf || dp_w_addr_o !== 10'h08E) begin
      errors++;
      $display("[TB] FAIL mid_beat2: got we=%h addr=%h expected we=f addr=08e", dp_data_we_o, dp_w_addr_o);
    end
    rst_n = 0; #1;
    checks++;
    if (all_outs !== '0 || miss_ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_reset_outs: got outs=%h ready=%b expected 0 and 1", all_outs, miss_ready_o);
    end
    bus.rvalid = 0;
    checks++;
    if (dw_addr.size() - nd !== 2 || tw_tag[tw_tag.size()-1] !== 22'h0) begin
      errors++;
      $display("[TB] FAIL mid_partial: got writes=%0d last_tag=%h expected 2 and 0",
               dw_addr.size() - nd, tw_tag[tw_tag.size()-1]);
    end
    @(posedge clk); #1;
    rst_n = 1;
    nd  = dw_addr.size();
    ndn = done_cyc.size();
    @(posedge clk); #1;
    miss_valid_i = 1;
    serve(0, 0, ndn + 1, 0, to);
    checks++;
    if (dw_addr.size() - nd !== 4 || tw_tag[tw_tag.size()-1] !== 22'h200001) begin
      errors++;
      $display("[TB] FAIL mid_recover: got writes=%0d tag=%h expected 4 and 200001",
               dw_addr.size() - nd, tw_tag[tw_tag.size()-1]);
    end
  endtask

  task automatic test_back_to_back();
    int ndn = done_cyc.size();
    int nr = rq_addr.size();
    int acc;
    bit to;
    rbase = 32'h5500_0000;
    @(posedge clk); #1;
    miss_valid_i = 1; miss_paddr_i = 32'h0000_2340; victim_tag_i = 22'h0;
    acc = cyc;
    serve(0, 1, ndn + 2, 0, to);
    checks++;
    if (done_cyc[ndn] - acc !== 7 || done_cyc[ndn+1] - done_cyc[ndn] !== 8) begin
      errors++;
      $display("[TB] FAIL b2b_timing: got %0d and %0d expected 7 and 8",
               done_cyc[ndn] - acc, done_cyc[ndn+1] - done_cyc[ndn]);
    end
    checks++;
    if (rq_addr.size() - nr !== 2 || tw_tag[tw_tag.size()-1] !== 22'h200002) begin
      errors++;
      $display("[TB] FAIL b2b_reqs: got reqs=%0d tag=%h expected 2 and 200002",
               rq_addr.size() - nr, tw_tag[tw_tag.size()-1]);
    end
  endtask

  task automatic test_stray_rvalid();
    int nd = dw_addr.size();
    int nt;
    int ndn;
    bit to;
    @(posedge clk); #1;
    bus.rvalid = 1; bus.rlast = 1; bus.rdata = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    clear_bus();
    checks++;
    if (dw_addr.size() !== nd) begin
      errors++;
      $display("[TB] FAIL stray_idle: got %0d writes expected 0", dw_addr.size() - nd);
    end
    rbase = 32'h6600_0000;
    nt  = tw_tag.size();
    ndn = done_cyc.size();
    @(posedge clk); #1;
    miss_valid_i = 1; miss_paddr_i = 32'h0000_4560; victim_tag_i = 22'h100004;
    serve(0, 0, ndn + 1, 0, to);
    bus.rvalid = 1; bus.rlast = 1; bus.rdata = 32'h6600_0004;
    repeat (2) @(posedge clk);
    #1;
    clear_bus();
    checks++;
    if (dw_addr.size() - nd !== 4 || tw_tag.size() - nt !== 2) begin
      errors++;
      $display("[TB] FAIL stray_after: got writes=%0d tags=%0d expected 4 and 2",
               dw_addr.size() - nd, tw_tag.size() - nt);
    end
  endtask

  initial begin
    miss_valid_i = 0;
    miss_paddr_i = 0;
    victim_tag_i = 0;
    dp_data_i    = 0;
    rbase        = 0;
    clear_bus();
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_stalls();
    test_reset_mid_refill();
    test_back_to_back();
    test_stray_rvalid();
    checks++;
    if (overlap_cnt !== 0) begin
      errors++;
      $display("[TB] FAIL we_overlap: got %0d cycles expected 0", overlap_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish by 200000 time units, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
